display_scan: RTL

Time-multiplexed 4-digit scanner that sits directly upstream of the 4-bit seven-segment decoder. It holds a 16-bit hex value and presents one nibble at a time to the decoder, together with a one-hot digit enable. Each digit is refreshed at a rate set by a prescaler. New values commit only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/display_pkg.sv | 28 ++
 rtl/scan_tick.sv | 31 +++
 rtl/display_scan.sv | 97 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the display scanner.
//   NDIG      : number of multiplexed digits
//   nibble_t  : one hex digit as presented to the segment decoder
//   digen_t   : one-hot digit enable vector
//   lzb_keep  : per-digit "keep lit" mask for leading-zero blanking
package display_pkg;

  localparam int NDIG = 4;

  typedef logic [3:0]      nibble_t;
  typedef logic [NDIG-1:0] digen_t;

  // Digit k (k >= 1) stays lit only if some digit at or above k is non-zero.
  // Digit 0 is always kept so a zero value still shows a single "0".
  function automatic digen_t lzb_keep(input logic [4*NDIG-1:0] d);
    digen_t m;
    logic   any_nz;
    m      = '0;
    any_nz = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      any_nz = any_nz | (|d[4*k +: 4]);
      m[k]   = any_nz;
    end
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Digit-slot prescaler.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : high during the last cycle of each CLK_DIV-cycle slot
module scan_tick
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit hex scanner feeding a seven-segment decoder.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   value  : 16-bit hex value, value[3:0] is the rightmost digit
//   load   : single-cycle strobe capturing value (committed at frame boundary)
//   lzb    : leading-zero blanking enable
//   blank  : forces all digit enables low
//   busy   : a loaded value is waiting for the next frame boundary
//   nib    : nibble of the digit currently being scanned
//   dig_en : one-hot active-high digit enable
module display_scan
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NDIG-1:0]    value,
  input  logic                 load,
  input  logic                 lzb,
  input  logic                 blank,
  output logic                 busy,
  output nibble_t              nib,
  output digen_t               dig_en
);

  logic                tick;
  logic [1:0]          idx;
  logic [4*NDIG-1:0]   pend;
  logic                pend_v;
  logic [4*NDIG-1:0]   disp;

  logic [1:0]          idx_nxt;
  logic [4*NDIG-1:0]   pend_nxt;
  logic                pend_v_nxt;
  logic [4*NDIG-1:0]   disp_nxt;
  logic                frame_end;
  digen_t              en_nxt;

  scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_end = tick && (idx == 2'd3);
  assign busy      = pend_v;

  always_comb begin
    idx_nxt    = tick ? idx + 2'd1 : idx;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    disp_nxt   = disp;
    if (frame_end) begin
      // A load landing on the boundary edge bypasses pend entirely.
      if (load) begin
        disp_nxt   = value;
        pend_v_nxt = 1'b0;
      end else if (pend_v) begin
        disp_nxt   = pend;
        pend_v_nxt = 1'b0;
      end
    end else if (load) begin
      pend_nxt   = value;
      pend_v_nxt = 1'b1;
    end

    // Outputs follow the next-state index and value so the new digit and
    // freshly committed data appear on the same edge the index advances.
    en_nxt = digen_t'(1) << idx_nxt;
    if (lzb) begin
      en_nxt = en_nxt & lzb_keep(disp_nxt);
    end
    if (blank) begin
      en_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      disp   <= '0;
      nib    <= '0;
      dig_en <= digen_t'(1);
    end else begin
      idx    <= idx_nxt;
      pend   <= pend_nxt;
      pend_v <= pend_v_nxt;
      disp   <= disp_nxt;
      nib    <= disp_nxt[{idx_nxt, 2'b00} +: 4];
      dig_en <= en_nxt;
    end
  end

endmodule
